// File: rtl/conv_s00_axi_regs.sv
// conv_s00_axi_regs: AXI4-Lite config register bank for the convolution core; define CONV_WRCOUNT_REG_EN to make word 3 a read-only write-commit counter
module conv_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
`ifdef CONV_WRCOUNT_REG_EN
  localparam int NWR = 3;
`else
  localparam int NWR = 4;
`endif
  logic          aw_held, w_held, aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    aw_idx, wr_idx;
  logic [DW-1:0] w_data, wr_data;
  logic [NB-1:0] w_strb, wr_strb;
  logic [DW-1:0] regs [NWR];
  logic [DW-1:0] word [4];
  logic          unused;
  assign unused        = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_AWREADY = S_AXI_ARESETN & !aw_held & !S_AXI_BVALID;
  assign S_AXI_WREADY  = S_AXI_ARESETN & !w_held & !S_AXI_BVALID;
  assign S_AXI_ARREADY = S_AXI_ARESETN & !S_AXI_RVALID;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit  = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_idx  = aw_held ? aw_idx : S_AXI_AWADDR[3:2];
  assign wr_data = w_held ? w_data : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
  assign cfg_reg0 = word[0];
  assign cfg_reg1 = word[1];
  assign cfg_reg2 = word[2];
  assign cfg_reg3 = word[3];
  // Hold whichever of AW/W arrives first; commit when the pair is complete
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
    end else begin
      if (aw_hs) aw_idx <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      aw_held      <= !commit & (aw_held | aw_hs);
      w_held       <= !commit & (w_held | w_hs);
      S_AXI_BVALID <= commit | (S_AXI_BVALID & !S_AXI_BREADY);
    end
  // Byte-lane merge of committed data into the writable words
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NWR; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NWR; i++)
        for (int b = 0; b < NB; b++)
          if (wr_idx == 2'(i) && wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
    end
`ifdef CONV_WRCOUNT_REG_EN
  logic [DW-1:0] wr_count;
  // Count every committed write, wrapping naturally
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) wr_count <= '0;
    else if (commit) wr_count <= wr_count + DW'(1);
`endif
  // Readable/exported view of the four words
  always_comb begin
    for (int i = 0; i < 4; i++) word[i] = '0;
    for (int i = 0; i < NWR; i++) word[i] = regs[i];
`ifdef CONV_WRCOUNT_REG_EN
    word[3] = wr_count;
`endif
  end
  // Read response: capture on AR handshake, hold until RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else begin
      if (ar_hs) S_AXI_RDATA <= word[S_AXI_ARADDR[3:2]];
      S_AXI_RVALID <= ar_hs | (S_AXI_RVALID & !S_AXI_RREADY);
    end
endmodule

// File: tb/tb_conv_s00_axi_regs.sv
// tb_conv_s00_axi_regs: self-checking bench for the S00_AXI register bank
module tb_conv_s00_axi_regs;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  awaddr = 0, araddr = 0, wstrb = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = 0, rdata, cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;
  logic [1:0]  bresp, rresp;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m [4];
  logic [31:0] cnt_m;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  conv_s00_axi_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_reg0(cfg_reg0), .cfg_reg1(cfg_reg1), .cfg_reg2(cfg_reg2), .cfg_reg3(cfg_reg3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cnt_m = cnt_m + 1;
`ifdef CONV_WRCOUNT_REG_EN
    if (a[3:2] == 2'd3) return;
`endif
    for (int b = 0; b < 4; b++) if (s[b]) m[a[3:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] exp_word(input logic [1:0] i);
`ifdef CONV_WRCOUNT_REG_EN
    if (i == 2'd3) return cnt_m;
`endif
    return m[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = 0;
    cnt_m = 0;
  endtask

  // Scoreboard: every completed R handshake pops one expected read value
  always @(negedge clk)
    if (rst_n && rvalid && rready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h with no read outstanding", rdata);
      end else check("rd_data", rdata, exp_q.pop_front());
    end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_go, w_go;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_go) awvalid = 0;
      if (w_go) wvalid = 0;
    end
    flag("wr_handshake_timeout", awvalid || wvalid, 1'b0);
    awvalid = 0; wvalid = 0;
    flag("wr_bvalid_set", bvalid, 1'b1);
    check("wr_bresp", 32'(bresp), 32'd0);
    model_write(a, d, s);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    flag("wr_bvalid_clr", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] e);
    logic go;
    araddr = a; arvalid = 1;
    exp_q.push_back(e);
    for (int n = 0; n < 20 && arvalid; n++) begin
      go = arready;
      @(posedge clk); #1;
      if (go) arvalid = 0;
    end
    flag("rd_handshake_timeout", arvalid, 1'b0);
    arvalid = 0;
    flag("rd_rvalid_set", rvalid, 1'b1);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    flag("rd_rvalid_clr", rvalid, 1'b0);
  endtask

  function automatic logic [31:0] rd_exp(input int i);
`ifdef CONV_WRCOUNT_REG_EN
    if (tbl[i].addr[3:2] == 2'd3) return cnt_m;
`endif
    return tbl[i].exp;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    tbl[0] = '{4'h0, 32'h00000001, 4'hF, 32'h00000001};
    tbl[1] = '{4'h4, 32'h00000002, 4'hF, 32'h00000002};
    tbl[2] = '{4'h8, 32'h00000003, 4'hF, 32'h00000003};
    tbl[3] = '{4'hC, 32'h00000004, 4'hF, 32'h00000004};
    tbl[4] = '{4'h0, 32'hAABBCCDD, 4'h2, 32'h0000CC01};
    tbl[5] = '{4'h5, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    tbl[6] = '{4'hB, 32'h11223344, 4'h9, 32'h11000044};
    tbl[7] = '{4'hE, 32'hFFFFFFFF, 4'h4, 32'h00FF0004};
    for (int k = 0; k < 3; k++) begin
      #60;
      check("rst_handshakes", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
    end
    #20 rst_n = 1;
    #1;
    check("rst_cfg0", cfg_reg0, 32'd0);
    check("rst_cfg1", cfg_reg1, 32'd0);
    check("rst_cfg2", cfg_reg2, 32'd0);
    check("rst_cfg3", cfg_reg3, 32'd0);
    @(posedge clk); #1;
    check("idle_readies", 32'({awready, wready, arready}), 32'd7);
    for (int i = 0; i < 4; i++) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
    for (int i = 0; i < 4; i++) axi_read(tbl[i].addr, rd_exp(i));
    for (int i = 4; i < 8; i++) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      axi_read(tbl[i].addr, rd_exp(i));
    end
    check("tbl_cfg0", cfg_reg0, exp_word(2'd0));
    check("tbl_cfg1", cfg_reg1, exp_word(2'd1));
    check("tbl_cfg2", cfg_reg2, exp_word(2'd2));
    check("tbl_cfg3", cfg_reg3, exp_word(2'd3));
    // W three cycles ahead of AW
    wdata = 32'h5A5A0000; wstrb = 4'hF; wvalid = 1;
    flag("wfirst_wready", wready, 1'b1);
    @(posedge clk); #1;
    wvalid = 0;
    flag("wfirst_wready_drop", wready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      flag("wfirst_no_bvalid", bvalid, 1'b0);
      @(posedge clk); #1;
    end
    awaddr = 4'h4; awvalid = 1;
    flag("wfirst_awready", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 0;
    model_write(4'h4, 32'h5A5A0000, 4'hF);
    flag("wfirst_bvalid", bvalid, 1'b1);
    check("wfirst_cfg1", cfg_reg1, 32'h5A5A0000);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    flag("wfirst_bvalid_clr", bvalid, 1'b0);
    @(posedge clk); #1;
    flag("wfirst_single_commit", bvalid, 1'b0);
    check("wfirst_readies", 32'({awready, wready}), 32'd3);
    // Backpressure with a same-edge read and write of word 2
    awaddr = 4'h8; wdata = 32'h0F0F0F0F; wstrb = 4'hF; araddr = 4'h8;
    awvalid = 1; wvalid = 1; arvalid = 1;
    check("bp_readies_pre", 32'({awready, wready, arready}), 32'd7);
    exp_q.push_back(exp_word(2'd2));
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(4'h8, 32'h0F0F0F0F, 4'hF);
    check("bp_cfg2", cfg_reg2, 32'h0F0F0F0F);
    for (int k = 0; k < 5; k++) begin
      check("bp_valids", 32'({bvalid, rvalid}), 32'd3);
      check("bp_rdata", rdata, 32'h11000044);
      check("bp_readies", 32'({awready, wready, arready}), 32'd0);
      @(posedge clk); #1;
    end
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    check("bp_valids_clr", 32'({bvalid, rvalid}), 32'd0);
    @(posedge clk); #1;
    check("bp_single_resp", 32'({bvalid, rvalid}), 32'd0);
    axi_read(4'h8, 32'h0F0F0F0F);
    // Asynchronous reset between AW and W
    awaddr = 4'h0; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    flag("arst_aw_held", awready, 1'b0);
    #2 rst_n = 0;
    #1;
    check("arst_handshakes", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
    check("arst_cfg1", cfg_reg1, 32'd0);
    check("arst_cfg2", cfg_reg2, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    #1;
    check("arst_readies_after", 32'({awready, wready, arready}), 32'd7);
    @(posedge clk); #1;
    axi_write(4'h4, 32'hCAFEF00D, 4'hF);
    check("arst_cfg1_new", cfg_reg1, 32'hCAFEF00D);
    check("arst_cfg0_new", cfg_reg0, 32'd0);
    check("arst_cfg3_new", cfg_reg3, exp_word(2'd3));
    axi_read(4'h4, 32'hCAFEF00D);
    axi_read(4'hC, exp_word(2'd3));
    @(posedge clk); #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_s00_axi_regs.md
# conv_s00_axi_regs

AXI4-Lite slave register bank on the S00_AXI port of the convolution IP. It is the responder for the AXI4-Lite master that configures the core. It holds four 32-bit configuration words, drives them to the convolution datapath, and returns them on read.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; word index is ADDR[3:2].
- S_AXI_ACLK  in  1  single clock; everything samples on the rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte-lane enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- cfg_reg0..cfg_reg3  out  32 each  current register contents, driven to the convolution core.

## Operation
- Reset: all registers, outputs, valids and holding flags are 0. ARREADY, AWREADY and WREADY are also 0 while reset is asserted.
- Write channel state consists of aw_held, w_held and BVALID.
  - AWREADY = !aw_held & !BVALID.
  - WREADY = !w_held & !BVALID.
- AW and W are accepted independently and in either order. Each accepted address or data beat is latched into its holding register.
- Commit happens on the edge where the second of the two handshakes completes. It may complete in the same cycle as the first.
  - The addressed word is updated per WSTRB lane; lanes whose strobe bit is 0 keep their old value.
  - aw_held and w_held clear.
  - BVALID is set.
- BVALID stays high until BREADY is sampled high. AWREADY and WREADY stay low for that whole time.
- Read: ARREADY = !RVALID. On the AR handshake edge:
  - RDATA is loaded with word ARADDR[3:2].
  - RVALID is set.
  - RDATA and RVALID hold until RREADY is sampled high.
- ADDR[1:0] is ignored. All 4 word indices decode; there is no SLVERR path.
- A read and a write to the same word on the same edge: the read returns the pre-write value.
- Reset asserted mid-transaction aborts it asynchronously. Any held beat is discarded, any pending response is dropped, and registers return to 0.

## Timing
- Write latency: BVALID is high in the cycle after the completing handshake edge. cfg_regN shows the new value in that same cycle.
- Read latency: RVALID is high in the cycle after the AR handshake edge.
- Back-to-back writes with AW, W and BREADY all held high: one commit every 2 cycles.
- Back-to-back reads with RREADY held high: one read every 2 cycles.
- The read and write paths are fully independent and may complete on the same edge.

## Configuration
- CONV_WRCOUNT_REG_EN defined:
  - Word 3 is read-only. It returns a 32-bit count of committed write transactions, counting every commit including those to word 3.
  - The count wraps from 0xFFFFFFFF to 0 and resets to 0.
  - Writes to word 3 still get OKAY but the data is discarded.
  - cfg_reg3 drives the counter value.
- CONV_WRCOUNT_REG_EN undefined: word 3 is an ordinary read/write register, identical to words 0-2.

## Test plan
- Reset check: hold reset for 200 ns, then release. Required: every ready/valid is 0 during reset, and cfg_reg0..3 = 0 after release.
- Sequential write/read-back: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read all four back. Required: reads return 1, 2, 3, 4 with macro off; words 0-2 = 1, 2, 3 and word 3 = 0x4 with macro on.
- Byte strobes: reg0 holds 0x00000001; write 0xAABBCCDD to reg0 with WSTRB = 4'b0010. Required: reg0 reads back 0x0000CC01.
- W-before-AW: drive W 3 cycles ahead of AW. Required: WREADY drops after the W capture, exactly one commit and one BVALID occur, and the data lands at the AW address.
- Backpressure: hold BREADY and RREADY low for 5 cycles. Required: BVALID, RVALID and RDATA stay stable; AWREADY, WREADY and ARREADY stay 0; each response completes exactly once when the ready rises.
- Async reset mid-write: assert reset after the AW handshake but before W. Required: all outputs go to 0 immediately, and the next write after release commits normally.
